key_pulse_bank: RTL and testbench

Multi-channel button conditioner that turns raw, bouncing push-button inputs into clean one-clock event pulses for the control FSMs. It divides the system clock down to a sample tick, synchronises and debounces each channel, and detects rising, falling or both edges. Holding a key past a delay produces auto-repeat pulses. It sits between the board key pins and every block that consumes key events, with one instance serving the whole key bank.

---
 rtl/key_pulse_bank.sv | 152 +++++++++++++++
 tb/tb_key_pulse_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_pulse_bank.sv
// rtl/key_pulse_bank.sv - multi-channel key debouncer with edge and auto-repeat pulses
module key_pulse_bank #(
  parameter int CH         = 5,
  parameter int DIV        = 1000000,
  parameter int STABLE     = 3,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] key_in,
  input  logic [1:0]    mode,
  input  logic          repeat_en,
  output logic [CH-1:0] level,
  output logic [CH-1:0] pulse,
  output logic [CH-1:0] hold,
  output logic          tick
);

  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW   = $clog2(STABLE + 1);
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  logic [DW-1:0] div_cnt;
  logic [CH-1:0] sync1;
  logic [CH-1:0] sync;
  logic          rise_en;
  logic          fall_en;
  logic          rep_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DW'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= key_in;
      sync  <= sync1;
    end
  end

  // mode 11 behaves as rising-only; falling-only mode also suppresses auto-repeat
  assign rise_en = (mode != 2'b01);
  assign fall_en = (mode == 2'b01) || (mode == 2'b10);
  assign rep_ok  = repeat_en && (mode != 2'b01);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [SW-1:0] stab_cnt;
    logic [RW-1:0] rcnt;
    logic          lvl_r;
    logic          pls_r;
    logic          hold_r;
    logic          flip;
    logic          rise;
    logic          fall;
    rep_state_t    st;

    assign flip = tick && (sync[g] != lvl_r) && (int'(stab_cnt) + 1 >= STABLE);
    assign rise = flip && !lvl_r;
    assign fall = flip && lvl_r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stab_cnt <= '0;
        lvl_r    <= 1'b0;
      end else if (tick) begin
        if (sync[g] == lvl_r) begin
          stab_cnt <= '0;
        end else if (flip) begin
          lvl_r    <= ~lvl_r;
          stab_cnt <= '0;
        end else if (int'(stab_cnt) < STABLE - 1) begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end
    end

    // a release on the same tick as a repeat expiry takes priority
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= IDLE;
        rcnt   <= '0;
        pls_r  <= 1'b0;
        hold_r <= 1'b0;
      end else begin
        pls_r <= 1'b0;
        if (rise) begin
          pls_r  <= rise_en;
          st     <= rep_ok ? WAIT : IDLE;
          rcnt   <= '0;
          hold_r <= 1'b0;
        end else if (fall) begin
          pls_r  <= fall_en;
          st     <= IDLE;
          rcnt   <= '0;
          hold_r <= 1'b0;
        end else if (!rep_ok) begin
          st     <= IDLE;
          rcnt   <= '0;
          hold_r <= 1'b0;
        end else if (tick) begin
          case (st)
            WAIT: begin
              if (int'(rcnt) + 1 >= REPEAT_DLY) begin
                pls_r  <= 1'b1;
                st     <= REPEAT;
                rcnt   <= '0;
                hold_r <= 1'b1;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end
            REPEAT: begin
              if (int'(rcnt) + 1 >= REPEAT_PER) begin
                pls_r <= 1'b1;
                rcnt  <= '0;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end
            default: begin
              rcnt <= '0;
            end
          endcase
        end
      end
    end

    assign level[g] = lvl_r;
    assign pulse[g] = pls_r;
    assign hold[g]  = hold_r;
  end

endmodule

// File: tb/tb_key_pulse_bank.sv
// tb/tb_key_pulse_bank.sv - directed and randomized bench for key_pulse_bank
module tb_key_pulse_bank;

  localparam int CH = 2;
  localparam int DIV = 4;
  localparam int STABLE = 3;
  localparam int RD = 5;
  localparam int RP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] key_in = '0;
  logic [1:0]    mode = 2'b00;
  logic          repeat_en = 1'b0;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic [CH-1:0] hold;
  logic          tick;

  key_pulse_bank #(
    .CH(CH), .DIV(DIV), .STABLE(STABLE), .REPEAT_DLY(RD), .REPEAT_PER(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .mode(mode), .repeat_en(repeat_en),
    .level(level), .pulse(pulse), .hold(hold), .tick(tick)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [CH-1:0] m_level, m_pulse, m_hold, kp1, kp2;
  logic          m_tick;
  int            ecount, tcount;
  int            last_agree [CH];
  int            press_t [CH];
  bit            rep_act [CH];
  int            pe [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0; m_pulse = '0; m_hold = '0; kp1 = '0; kp2 = '0; m_tick = 1'b0;
    ecount = 0; tcount = 0;
    for (int i = 0; i < CH; i++) begin
      last_agree[i] = 0; press_t[i] = 0; rep_act[i] = 1'b0;
    end
  endtask

  // Level accepted once STABLE successive tick samples all disagree with it;
  // repeats fall on tick offsets RD, RD+RP, RD+2RP... from the accepting tick.
  task automatic model_edge();
    logic tedge, rise, fall, en;
    int   n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ecount++;
    tedge = m_tick;
    m_pulse = '0;
    if (tedge) tcount++;
    en = repeat_en && (mode != 2'b01);
    for (int i = 0; i < CH; i++) begin
      rise = 1'b0; fall = 1'b0;
      if (tedge) begin
        if (kp2[i] == m_level[i]) last_agree[i] = tcount;
        else if (tcount - last_agree[i] >= STABLE) begin
          rise = !m_level[i]; fall = m_level[i];
          m_level[i] = !m_level[i];
          last_agree[i] = tcount;
        end
      end
      if (rise) begin
        m_pulse[i] = (mode != 2'b01); rep_act[i] = en; press_t[i] = tcount;
      end else if (fall) begin
        m_pulse[i] = (mode == 2'b01) || (mode == 2'b10); rep_act[i] = 1'b0;
      end else if (!en) begin
        rep_act[i] = 1'b0;
      end else if (tedge && rep_act[i]) begin
        n = tcount - press_t[i];
        if (n == RD || (n > RD && (n - RD) % RP == 0)) m_pulse[i] = 1'b1;
      end
      m_hold[i] = rep_act[i] && (tcount - press_t[i] >= RD);
    end
    m_tick = (ecount % DIV == DIV - 1);
    kp2 = kp1;
    kp1 = key_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("level", level, m_level);
    check("pulse", pulse, m_pulse);
    check("hold", hold, m_hold);
    check("tick", tick, m_tick);
    if (pulse[0]) pe.push_back(ecount);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  int e0;

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", level, 0);
    check("rst_pulse", pulse, 0);
    check("rst_hold", hold, 0);
    check("rst_tick", tick, 0);
    run(3);
    rst_n = 1'b1;

    // idle after reset: first tick DIV clk later
    pe.delete();
    run(3);
    check("s1_first_tick", tick, 1);
    run(37);
    check("s1_level", level, 0);
    check("s1_pulses", pe.size(), 0);

    // mode 00 press/release: one pulse on press only
    pe.delete();
    key_in[0] = 1'b1;
    e0 = ecount;
    for (int k = 0; k < 20 && !level[0]; k++) cyc();
    check("s2_level_up", level[0], 1);
    check("s2_lat_max", (ecount - e0 <= 14), 1);
    check("s2_lat_min", (ecount - e0 >= 11), 1);
    run(60 - (ecount - e0));
    key_in[0] = 1'b0;
    run(40);
    check("s2_pulses", pe.size(), 1);
    check("s2_level_dn", level, 0);

    // bounce faster than STABLE ticks is rejected
    pe.delete();
    for (int k = 0; k < 5; k++) begin
      key_in[0] = ~key_in[0];
      run(4);
    end
    key_in[0] = 1'b0;
    run(20);
    check("s3_pulses", pe.size(), 0);
    check("s3_level", level, 0);

    // mode 10: pulse on both edges
    mode = 2'b10;
    pe.delete();
    key_in[0] = 1'b1;
    run(40);
    key_in[0] = 1'b0;
    run(40);
    check("s4_pulses", pe.size(), 2);

    // auto-repeat schedule
    mode = 2'b00;
    repeat_en = 1'b1;
    pe.delete();
    key_in[0] = 1'b1;
    run(80);
    check("s5_hold_on", hold[0], 1);
    key_in[0] = 1'b0;
    run(40);
    check("s5_hold_off", hold, 0);
    check("s5_count_ok", (pe.size() >= 4), 1);
    if (pe.size() >= 4) begin
      check("s5_gap_first", pe[1] - pe[0], 20);
      check("s5_gap_2", pe[2] - pe[1], 8);
      check("s5_gap_3", pe[3] - pe[2], 8);
    end

    // async reset mid-repeat, key released under reset
    key_in[0] = 1'b1;
    run(60);
    check("s6_hold_pre", hold[0], 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("s6_level", level, 0);
    check("s6_pulse", pulse, 0);
    check("s6_hold", hold, 0);
    check("s6_tick", tick, 0);
    key_in[0] = 1'b0;
    run(5);
    rst_n = 1'b1;
    pe.delete();
    run(40);
    check("s6_no_pulse", pe.size(), 0);
    check("s6_level_post", level, 0);

    // randomized keys, mode and repeat_en against the reference model
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 23) == 0) key_in[i] = ~key_in[i];
      if ($urandom_range(0, 199) == 0) repeat_en = ~repeat_en;
      if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
